// File: rtl/mdio_phy_ctrl.sv
// mdio_phy_ctrl: brings up the PHY over MDIO (soft reset, config), then polls link and shares MDIO with one host.
module mdio_phy_ctrl #(
    parameter logic [4:0]  PHY_ADDR      = 5'd1,
    parameter logic [15:0] BMCR_CFG      = 16'h1140,
    parameter int          POR_WAIT      = 1000000,
    parameter int          POLL_PERIOD   = 5000000,
    parameter int          MAX_RST_POLLS = 16,
    parameter int          DONE_TIMEOUT  = 4096
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mdio_start,
    output logic        mdio_is_rd,
    output logic [4:0]  mdio_phy_addr,
    output logic [4:0]  mdio_reg_addr,
    output logic [15:0] mdio_wr_data,
    input  logic [15:0] mdio_rd_data,
    input  logic        mdio_done,
    input  logic        host_req,
    input  logic        host_is_rd,
    input  logic [4:0]  host_reg_addr,
    input  logic [15:0] host_wr_data,
    output logic        host_ack,
    output logic [15:0] host_rd_data,
    output logic        init_done,
    output logic        init_err,
    output logic        link_up
);
    localparam int PW = $clog2(POR_WAIT + 1);
    localparam int TW = $clog2(POLL_PERIOD + 1);
    localparam int RW = $clog2(MAX_RST_POLLS + 1);
    localparam int DW = $clog2(DONE_TIMEOUT + 1);
    localparam logic [PW-1:0] POR_LAST  = PW'(POR_WAIT - 1);
    localparam logic [TW-1:0] POLL_LAST = TW'(POLL_PERIOD - 1);
    localparam logic [RW-1:0] RST_MAX   = RW'(MAX_RST_POLLS);
    localparam logic [DW-1:0] DONE_LAST = DW'(DONE_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_POR, S_RST_WR, S_RST_RD, S_RST_GAP, S_CFG_WR, S_IDLE, S_LINK_RD, S_HOST, S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] por_q, por_d;
    logic [TW-1:0] poll_q, poll_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [DW-1:0] wd_q, wd_d;
    logic          sent_q, sent_d, start_q, start_d, pend_q, pend_d, ack_q, ack_d;
    logic          init_done_q, init_done_d, init_err_q, init_err_d, link_q, link_d;
    logic          h_rd_q, h_rd_d;
    logic [4:0]    h_reg_q, h_reg_d;
    logic [15:0]   h_wd_q, h_wd_d, h_rdata_q, h_rdata_d;
    logic          txn, done, timer_on, expire, timeout;

    assign txn      = state_q inside {S_RST_WR, S_RST_RD, S_CFG_WR, S_LINK_RD, S_HOST};
    assign done     = sent_q & mdio_done;
    assign timeout  = sent_q & ~mdio_done & (wd_q == DONE_LAST);
    assign timer_on = init_done_q & (state_q != S_ERR);
    assign expire   = timer_on & (poll_q == POLL_LAST);

    always_comb begin
        state_d     = state_q;
        por_d       = por_q;
        poll_d      = timer_on ? (expire ? '0 : poll_q + 1'b1) : poll_q;
        pend_d      = pend_q | expire;
        retry_d     = retry_q;
        wd_d        = sent_q ? wd_q + 1'b1 : '0;
        sent_d      = sent_q & ~mdio_done;
        start_d     = txn & ~sent_q;
        ack_d       = 1'b0;
        init_done_d = init_done_q;
        init_err_d  = init_err_q;
        link_d      = link_q;
        h_rd_d      = h_rd_q;
        h_reg_d     = h_reg_q;
        h_wd_d      = h_wd_q;
        h_rdata_d   = h_rdata_q;
        if (txn && !sent_q)
            sent_d = 1'b1;
        case (state_q)
            S_POR: begin
                por_d   = por_q + 1'b1;
                state_d = (por_q == POR_LAST) ? S_RST_WR : S_POR;
            end
            S_RST_WR: state_d = done ? S_RST_RD : S_RST_WR;
            S_RST_RD: if (done) begin
                retry_d = retry_q + 1'b1;
                state_d = !mdio_rd_data[15] ? S_CFG_WR : (retry_d < RST_MAX) ? S_RST_GAP : S_ERR;
            end
            S_RST_GAP: state_d = S_RST_RD;
            S_CFG_WR: if (done) begin
                init_done_d = 1'b1;
                poll_d      = '0;
                state_d     = S_IDLE;
            end
            // the ack cycle counts as the idle gap, so a poll cannot sneak in ahead of a held host_req
            S_IDLE: if (!ack_q && host_req) begin
                h_rd_d  = host_is_rd;
                h_reg_d = host_reg_addr;
                h_wd_d  = host_wr_data;
                state_d = S_HOST;
            end else if (!ack_q && pend_q) begin
                state_d = S_LINK_RD;
            end
            S_LINK_RD: if (done) begin
                link_d  = mdio_rd_data[2];
                pend_d  = expire;
                state_d = S_IDLE;
            end
            S_HOST: if (done) begin
                ack_d     = 1'b1;
                h_rdata_d = h_rd_q ? mdio_rd_data : h_rdata_q;
                state_d   = S_IDLE;
            end
            default: ;
        endcase
        if (timeout)
            state_d = S_ERR;
        if (state_d == S_ERR) begin
            init_err_d = 1'b1;
            link_d     = 1'b0;
            sent_d     = 1'b0;
            start_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_POR;
            por_q       <= '0;
            poll_q      <= '0;
            retry_q     <= '0;
            wd_q        <= '0;
            sent_q      <= 1'b0;
            start_q     <= 1'b0;
            pend_q      <= 1'b0;
            ack_q       <= 1'b0;
            init_done_q <= 1'b0;
            init_err_q  <= 1'b0;
            link_q      <= 1'b0;
            h_rd_q      <= 1'b0;
            h_reg_q     <= '0;
            h_wd_q      <= '0;
            h_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            por_q       <= por_d;
            poll_q      <= poll_d;
            retry_q     <= retry_d;
            wd_q        <= wd_d;
            sent_q      <= sent_d;
            start_q     <= start_d;
            pend_q      <= pend_d;
            ack_q       <= ack_d;
            init_done_q <= init_done_d;
            init_err_q  <= init_err_d;
            link_q      <= link_d;
            h_rd_q      <= h_rd_d;
            h_reg_q     <= h_reg_d;
            h_wd_q      <= h_wd_d;
            h_rdata_q   <= h_rdata_d;
        end
    end

    assign mdio_start    = start_q;
    assign mdio_phy_addr = PHY_ADDR;
    assign mdio_is_rd    = (state_q == S_RST_RD) || (state_q == S_LINK_RD) || (state_q == S_HOST && h_rd_q);
    assign mdio_reg_addr = state_q == S_LINK_RD ? 5'd1 : state_q == S_HOST ? h_reg_q : 5'd0;
    assign mdio_wr_data  = state_q == S_RST_WR ? 16'h8000 : state_q == S_CFG_WR ? BMCR_CFG :
                           state_q == S_HOST ? h_wd_q : 16'h0000;
    assign host_ack      = ack_q;
    assign host_rd_data  = h_rdata_q;
    assign init_done     = init_done_q;
    assign init_err      = init_err_q;
    assign link_up       = link_q;
endmodule

// File: doc/mdio_phy_ctrl.md
Name: mdio_phy_ctrl

Overview:
Sequencer that owns the mdio_driver command port and brings the Ethernet PHY up without software. It waits out power-on, soft-resets the PHY through BMCR (reg 0), polls until reset self-clears, then writes the configured BMCR value. Afterwards it periodically reads BMSR (reg 1) to publish link status and shares the MDIO resource with a single host requester.

Parameters:
PHY_ADDR, 5'd1, PHY address placed on every transaction
BMCR_CFG, 16'h1140, BMCR value written after reset (autoneg enabled, 1000M full duplex)
POR_WAIT, 1000000, clk cycles from reset release to the first transaction
POLL_PERIOD, 5000000, clk cycles between BMSR link polls
MAX_RST_POLLS, 16, BMCR reads allowed while bit 15 is still set
DONE_TIMEOUT, 4096, clk cycles allowed per transaction before declaring an error

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
mdio_start  out  1  one-cycle pulse that launches a driver transaction
mdio_is_rd  out  1  1 = read, 0 = write
mdio_phy_addr  out  5  always PHY_ADDR
mdio_reg_addr  out  5  register address
mdio_wr_data  out  16  write data
mdio_rd_data  in  16  read data, valid when mdio_done=1
mdio_done  in  1  driver o_vld; one-cycle pulse at the end of every read or write
host_req  in  1  host request; held high until host_ack
host_is_rd  in  1  host read/write select
host_reg_addr  in  5  host register address
host_wr_data  in  16  host write data
host_ack  out  1  one-cycle pulse when the host transaction completes
host_rd_data  out  16  captured read data; valid while host_ack=1, then held
init_done  out  1  high once the configuration write has completed
init_err  out  1  sticky; set on timeout or reset-poll exhaustion
link_up  out  1  BMSR bit 2 from the latest poll

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: every output is 0 except mdio_phy_addr, which is PHY_ADDR. Counters, pending flag and retry count are cleared. Reset mid-transaction aborts it immediately; any mdio_done that arrives later is ignored.
- Issue rule:
  - The controller enters an issue state and drives is_rd, reg_addr and wr_data in that same cycle.
  - mdio_start=1 for exactly one cycle, on the next cycle.
  - is_rd, reg_addr and wr_data stay stable until mdio_done is sampled.
  - Only one transaction is outstanding at a time.
  - A watchdog counts the cycles spent waiting for mdio_done. If it reaches DONE_TIMEOUT, the controller goes to ERR.
- State machine:
  - POR: count POR_WAIT cycles, then go to RST_WR.
  - RST_WR: write reg 0 = 16'h8000. On done, go to RST_RD.
  - RST_RD: read reg 0 and increment the retry count. On done:
    - bit 15 = 0 → CFG_WR.
    - bit 15 = 1 and retry count < MAX_RST_POLLS → RST_RD again, with one idle cycle between reads.
    - otherwise → ERR.
  - CFG_WR: write reg 0 = BMCR_CFG. On done, set init_done, restart the poll timer and go to IDLE.
  - IDLE: the poll timer free-runs. On expiry it sets poll_pending and reloads.
    - host_req=1 → HOST (host has priority).
    - else poll_pending=1 → LINK_RD.
  - LINK_RD: read reg 1. On done, link_up <= rd_data[2], clear poll_pending, return to IDLE.
  - HOST: latch the host fields, then issue the transaction. On done:
    - pulse host_ack.
    - if it was a read, host_rd_data <= mdio_rd_data.
    - return to IDLE.
  - ERR: set init_err, link_up=0, no further transactions. Leave only via rst.
- Host and poll interaction:
  - host_req is ignored before init_done.
  - If the poll timer expires during HOST, poll_pending stays set and LINK_RD follows immediately after.
  - If host_req stays high after host_ack, a new host transaction starts only after one IDLE cycle. A poll_pending raised meanwhile still loses to the host.
  - A host write that clears BMCR bit 12 or sets bit 15 is not tracked; init_done stays 1.
- Counters: widths are $clog2(parameter+1). No wrap-around: the timer reloads at terminal count.

Test Plan:
1. Bring-up, sim params POR_WAIT=16, POLL_PERIOD=64, DONE_TIMEOUT=100. PHY model returns BMCR=16'h8000 twice, then 16'h1140. Required: writes (0,8000) → 3 reads of reg 0 → write (0,1140); init_done=1 about 1 cycle after the last done; no start before cycle 16.
2. Link poll: BMSR model returns 16'h796D. Required: link_up=1 within 64+transaction cycles. Model then returns 16'h7969: link_up drops after the next poll; spacing between reg-1 reads ≥64 cycles.
3. Host arbitration: host_req with read of reg 2 (PHY returns 16'h0141) asserted in the same cycle the poll timer expires. Required: host read issued first; host_ack with host_rd_data=16'h0141; the reg-1 read starts immediately after.
4. Host before init: host_req asserted during POR. Required: no host_ack until after init_done; host transaction is the first issued after CFG_WR.
5. Reset-poll exhaustion: model keeps BMCR bit 15 = 1. Required: exactly 16 reads of reg 0, then init_err=1, init_done=0, no further mdio_start.
6. Timeout and reset: model withholds mdio_done. Required: init_err=1 after 100 cycles. Then assert rst for 1 cycle mid-transaction: all outputs return to reset values and the POR wait restarts.
